// File: rtl/l2_ctrl_pkg.sv
// Shared types and defaults for the lint-slave L2 bank controller.
package l2_ctrl_pkg;

   localparam logic [31:0] DEF_BASE_ADDR = 32'h1C00_0000;
   localparam logic [31:0] DEF_ERR_RDATA = 32'hBADC_AB1E;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // addr holds the full word offset; the top keeps only the low AW bits.
   typedef struct packed {
      logic        valid;
      logic        in_range;
      logic        wen;
      logic [29:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } s1_t;

   typedef struct packed {
      logic valid;
      logic in_range;
      logic wen;
   } s2_t;

   localparam s1_t S1_RST = '{valid: 1'b0, in_range: 1'b0, wen: 1'b1,
                              addr: '0, wdata: '0, be: '0};
   localparam s2_t S2_RST = '{valid: 1'b0, in_range: 1'b0, wen: 1'b1};

endpackage

// File: rtl/l2_init_sweeper.sv
// Post-reset zero sweep: walks every word index once, then raises done.
module l2_init_sweeper #(
   parameter int unsigned AW            = 15,
   parameter bit          INIT_ON_RESET = 1'b1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   output logic          sweep_o,
   output logic [AW-1:0] idx_o,
   output logic          last_o
);

   logic [AW-1:0] idx_q, idx_d;
   logic          done_q, done_d;

   always_comb begin
      idx_d  = idx_q;
      done_d = done_q;
      if (!done_q) begin
         idx_d = idx_q + AW'(1);
         if (&idx_q) done_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         idx_q  <= '0;
         done_q <= !INIT_ON_RESET;
      end else begin
         idx_q  <= idx_d;
         done_q <= done_d;
      end
   end

   // Held off while reset is asserted so the bank sees no strobes during reset.
   assign sweep_o = ~done_q & ~rst_i;
   assign idx_o   = idx_q;
   assign last_o  = sweep_o & (&idx_q);

endmodule

// File: rtl/lint_l2_bank_ctrl.sv
// Lint-slave bank controller: range check, two-stage pipeline to a single-port SRAM.
module lint_l2_bank_ctrl
   import l2_ctrl_pkg::*;
#(
   parameter int unsigned BANK_WORDS    = 32768,
   parameter logic [31:0] BASE_ADDR     = DEF_BASE_ADDR,
   parameter bit          INIT_ON_RESET = 1'b1,
   parameter logic [31:0] ERR_RDATA     = DEF_ERR_RDATA,
   localparam int unsigned AW           = $clog2(BANK_WORDS)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          lint_req_i,
   input  logic [31:0]   lint_add_i,
   input  logic          lint_wen_i,
   input  logic [31:0]   lint_wdata_i,
   input  logic [3:0]    lint_be_i,
   output logic          lint_gnt_o,
   output logic          lint_r_valid_o,
   output logic [31:0]   lint_r_rdata_o,
   output logic          lint_r_opc_o,
   input  logic          stall_i,
   output logic          mem_csn_o,
   output logic          mem_wen_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [31:0]   mem_wdata_o,
   output logic [3:0]    mem_be_o,
   input  logic [31:0]   mem_rdata_i,
   output logic          init_done_o,
   output logic [15:0]   err_cnt_o
);

   localparam logic [31:0] BANK_BYTES = 32'(BANK_WORDS) << 2;

   state_e        state_q, state_d;
   s1_t           s1_q, s1_d;
   s2_t           s2_q, s2_d;
   logic [15:0]   err_cnt_q, err_cnt_d;
   logic [31:0]   off;
   logic          sweep;
   logic [AW-1:0] sweep_idx;
   logic          sweep_last;
   logic          unused_bits;

   l2_init_sweeper #(
      .AW            (AW),
      .INIT_ON_RESET (INIT_ON_RESET)
   ) u_sweeper (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .sweep_o (sweep),
      .idx_o   (sweep_idx),
      .last_o  (sweep_last)
   );

   assign lint_gnt_o = lint_req_i & (state_q == ST_RUN) & ~stall_i;

   // Below-base addresses wrap to a huge offset and fail the same compare.
   assign off = lint_add_i - BASE_ADDR;

   always_comb begin
      state_d = state_q;
      if (state_q == ST_INIT && sweep_last) state_d = ST_RUN;

      s1_d       = s1_q;
      s1_d.valid = lint_gnt_o;
      if (lint_gnt_o) begin
         s1_d.in_range = (off < BANK_BYTES);
         s1_d.wen      = lint_wen_i;
         s1_d.addr     = off[31:2];
         s1_d.wdata    = lint_wdata_i;
         s1_d.be       = lint_be_i;
      end

      s2_d = '{valid: s1_q.valid, in_range: s1_q.in_range, wen: s1_q.wen};

      err_cnt_d = err_cnt_q;
      if (s2_q.valid && !s2_q.in_range && err_cnt_q != 16'hFFFF)
         err_cnt_d = err_cnt_q + 16'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= INIT_ON_RESET ? ST_INIT : ST_RUN;
         s1_q      <= S1_RST;
         s2_q      <= S2_RST;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   always_comb begin
      if (sweep) begin
         mem_csn_o   = 1'b0;
         mem_wen_o   = 1'b0;
         mem_addr_o  = sweep_idx;
         mem_wdata_o = '0;
         mem_be_o    = 4'hF;
      end else begin
         mem_csn_o   = ~(s1_q.valid & s1_q.in_range);
         mem_wen_o   = s1_q.wen;
         mem_addr_o  = s1_q.addr[AW-1:0];
         mem_wdata_o = s1_q.wdata;
         mem_be_o    = s1_q.be;
      end
   end

   always_comb begin
      lint_r_rdata_o = '0;
      if (s2_q.valid) begin
         if (!s2_q.in_range)  lint_r_rdata_o = ERR_RDATA;
         else if (s2_q.wen)   lint_r_rdata_o = mem_rdata_i;
      end
   end

   assign lint_r_valid_o = s2_q.valid;
   assign lint_r_opc_o   = s2_q.valid & ~s2_q.in_range;
   assign init_done_o    = (state_q == ST_RUN);
   assign err_cnt_o      = err_cnt_q;

   // Byte-lane bits and the word-offset bits above the bank depth are not needed.
   assign unused_bits = ^{off[1:0], s1_q.addr};

endmodule
